// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle.
//   Inputs to the fetch unit : runEn (start permit), romData (ROM byte at romAddr),
//                              pcLoad / pcLoadAddr (jump request, honoured at X3).
//   Outputs from fetch unit  : romAddr (PC), cycle (phase 0..7), sync (X3 marker),
//                              opr / opa (first-word nibbles), operand2 (second byte),
//                              secondWord (second instruction cycle), exec (execute cycle).
// The master modport is the fetch unit; the slave modport is the ROM/decoder side.
interface instruction_fetch_if;
  logic        runEn;
  logic [7:0]  romData;
  logic        pcLoad;
  logic [11:0] pcLoadAddr;
  logic [11:0] romAddr;
  logic [2:0]  cycle;
  logic        sync;
  logic [3:0]  opr;
  logic [3:0]  opa;
  logic [7:0]  operand2;
  logic        secondWord;
  logic        exec;

  modport master (
    input  runEn, romData, pcLoad, pcLoadAddr,
    output romAddr, cycle, sync, opr, opa, operand2, secondWord, exec
  );

  modport slave (
    output runEn, romData, pcLoad, pcLoadAddr,
    input  romAddr, cycle, sync, opr, opa, operand2, secondWord, exec
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit for a 4-bit CPU with an 8-phase instruction cycle
// (A1,A2,A3,M1,M2,X1,X2,X3 = cycle 0..7).
//   clk  : system clock, all state changes on its rising edge
//   rstN : asynchronous active-low reset
//   bus  : instruction_fetch_if.master (see interface file for signal list)
// The ROM byte is captured at the M2 edge. A two-word opcode spends a second
// instruction cycle fetching its operand byte; exec flags the cycle in which the
// decoder should act. The PC advances (or jumps) at the X3 edge.
module instruction_fetch #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input logic                   clk,
  input logic                   rstN,
  instruction_fetch_if.master   bus
);

  typedef enum logic [0:0] {StFirst, StSecond} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cycle_q, cycle_d;
  logic [11:0] pc_q, pc_d;
  logic [3:0]  opr_q, opr_d;
  logic [3:0]  opa_q, opa_d;
  logic [7:0]  operand2_q, operand2_d;
  logic        exec_q, exec_d;
  logic        second_word;
  logic        sync;

  localparam logic [2:0] CycM2 = 3'd4;
  localparam logic [2:0] CycX3 = 3'd7;

  // JCN, FIM (OPA[0]==0), JUN, JMS and ISZ carry a second byte.
  function automatic logic is_two_word(input logic [7:0] code);
    logic res;
    case (code[7:4])
      4'h1, 4'h4, 4'h5, 4'h7: res = 1'b1;
      4'h2:                   res = ~code[0];
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // FSM: state register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= StFirst;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A jump at X3 always lands on a fresh first word.
  always_comb begin
    state_d = state_q;
    if (cycle_q == CycX3) begin
      if (state_q == StFirst && is_two_word({opr_q, opa_q}) && !bus.pcLoad) begin
        state_d = StSecond;
      end else begin
        state_d = StFirst;
      end
    end
  end

  // FSM: outputs
  always_comb begin
    second_word = (state_q == StSecond);
    sync        = (cycle_q == CycX3);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  always_comb begin
    cycle_d    = cycle_q;
    pc_d       = pc_q;
    opr_d      = opr_q;
    opa_d      = opa_q;
    operand2_d = operand2_q;
    exec_d     = exec_q;

    // Only A1 may stall; once started, an instruction cycle runs to X3.
    if (cycle_q != 3'd0 || bus.runEn) begin
      cycle_d = cycle_q + 3'd1;
    end

    if (cycle_q == CycM2) begin
      if (state_q == StFirst) begin
        opr_d  = bus.romData[7:4];
        opa_d  = bus.romData[3:0];
        exec_d = ~is_two_word(bus.romData);
      end else begin
        operand2_d = bus.romData;
        exec_d     = 1'b1;
      end
    end

    if (cycle_q == CycX3) begin
      pc_d = bus.pcLoad ? bus.pcLoadAddr : pc_q + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cycle_q    <= 3'd0;
      pc_q       <= RESET_PC;
      opr_q      <= 4'h0;
      opa_q      <= 4'h0;
      operand2_q <= 8'h00;
      exec_q     <= 1'b0;
    end else begin
      cycle_q    <= cycle_d;
      pc_q       <= pc_d;
      opr_q      <= opr_d;
      opa_q      <= opa_d;
      operand2_q <= operand2_d;
      exec_q     <= exec_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are driven from registers only.
  assign bus.romAddr    = pc_q;
  assign bus.cycle      = cycle_q;
  assign bus.sync       = sync;
  assign bus.opr        = opr_q;
  assign bus.opa        = opa_q;
  assign bus.operand2   = operand2_q;
  assign bus.secondWord = second_word;
  assign bus.exec       = exec_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a ROM array feeds romData, expected
// per-instruction results are queued as each step is issued and compared when
// the DUT reaches M2 and after X3.
module tb_instruction_fetch;

  logic clk;
  logic rstN;
  logic [7:0] rom [4096];

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC(12'h000)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bus)
  );

  assign bus.romData = rom[bus.romAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [7:0]  op2;
    logic        exec;
    logic        sec;
    logic [11:0] addr_after;
    logic        sec_after;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(input string tag, input logic [3:0] opr, input logic [3:0] opa,
                      input logic [7:0] op2, input logic exec, input logic sec,
                      input logic [11:0] addr_after, input logic sec_after);
    exp_t e;
    e.tag = tag; e.opr = opr; e.opa = opa; e.op2 = op2; e.exec = exec; e.sec = sec;
    e.addr_after = addr_after; e.sec_after = sec_after;
    sb.push_back(e);
  endtask

  // One full instruction cycle from A1. pcLoad is held high with a junk target at
  // every phase except X3, where the requested (pl, pla) is applied.
  task automatic run_cycle(input logic pl, input logic [11:0] pla, input bit drop);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb.pop_front();
    bus.runEn      = 1'b1;
    bus.pcLoad     = 1'b1;
    bus.pcLoadAddr = 12'hBAD;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk({e.tag, ":cycle"}, 32'(bus.cycle), 32'(i));
      if (drop && i == 3) bus.runEn = 1'b0;
      if (i == 5) begin
        chk({e.tag, ":opr"},      32'(bus.opr),        32'(e.opr));
        chk({e.tag, ":opa"},      32'(bus.opa),        32'(e.opa));
        chk({e.tag, ":operand2"}, 32'(bus.operand2),   32'(e.op2));
        chk({e.tag, ":exec"},     32'(bus.exec),       32'(e.exec));
        chk({e.tag, ":second"},   32'(bus.secondWord), 32'(e.sec));
      end
      if (i == 6) chk({e.tag, ":sync_x2"}, 32'(bus.sync), 32'd0);
      if (i == 7) begin
        chk({e.tag, ":sync_x3"}, 32'(bus.sync), 32'd1);
        bus.pcLoad     = pl;
        bus.pcLoadAddr = pla;
      end
    end
    step();
    bus.pcLoad = 1'b0;
    chk({e.tag, ":cycle_wrap"},   32'(bus.cycle),      32'd0);
    chk({e.tag, ":romAddr"},      32'(bus.romAddr),    32'(e.addr_after));
    chk({e.tag, ":second_after"}, 32'(bus.secondWord), 32'(e.sec_after));
    chk({e.tag, ":sync_a1"},      32'(bus.sync),       32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ":cycle"},    32'(bus.cycle),      32'd0);
    chk({tag, ":romAddr"},  32'(bus.romAddr),    32'h000);
    chk({tag, ":opr"},      32'(bus.opr),        32'd0);
    chk({tag, ":opa"},      32'(bus.opa),        32'd0);
    chk({tag, ":operand2"}, 32'(bus.operand2),   32'd0);
    chk({tag, ":exec"},     32'(bus.exec),       32'd0);
    chk({tag, ":second"},   32'(bus.secondWord), 32'd0);
    chk({tag, ":sync"},     32'(bus.sync),       32'd0);
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 8'h00;
    rom[12'h000] = 8'hD5;  // LDM 5
    rom[12'h001] = 8'h40;  // JUN ...
    rom[12'h002] = 8'h23;  //   ... low byte
    rom[12'h423] = 8'h22;  // FIM
    rom[12'h424] = 8'h5A;  //   operand
    rom[12'h425] = 8'h21;  // SRC
    rom[12'h426] = 8'h1C;  // JCN, jumped away from in its first cycle
    rom[12'hFFF] = 8'hA3;  // one-word at top of ROM

    rstN           = 1'b0;
    bus.runEn      = 1'b0;
    bus.pcLoad     = 1'b0;
    bus.pcLoadAddr = 12'h000;
    step();
    step();
    chk_reset_state("reset");
    rstN = 1'b1;

    // tag, opr, opa, op2, exec, sec @M2 ; romAddr, secondWord after X3
    push("d5_one_word",  4'hD, 4'h5, 8'h00, 1'b1, 1'b0, 12'h001, 1'b0);
    run_cycle(1'b0, 12'h000, 1'b0);
    push("jun_first",    4'h4, 4'h0, 8'h00, 1'b0, 1'b0, 12'h002, 1'b1);
    run_cycle(1'b0, 12'h000, 1'b0);
    push("jun_second",   4'h4, 4'h0, 8'h23, 1'b1, 1'b1, 12'h423, 1'b0);
    run_cycle(1'b1, 12'h423, 1'b0);
    push("fim_first",    4'h2, 4'h2, 8'h23, 1'b0, 1'b0, 12'h424, 1'b1);
    run_cycle(1'b0, 12'h000, 1'b0);
    push("fim_second",   4'h2, 4'h2, 8'h5A, 1'b1, 1'b1, 12'h425, 1'b0);
    run_cycle(1'b0, 12'h000, 1'b0);
    push("src_one_word", 4'h2, 4'h1, 8'h5A, 1'b1, 1'b0, 12'h426, 1'b0);
    run_cycle(1'b0, 12'h000, 1'b0);
    push("jcn_jump_pri", 4'h1, 4'hC, 8'h5A, 1'b0, 1'b0, 12'hFFF, 1'b0);
    run_cycle(1'b1, 12'hFFF, 1'b0);
    push("pc_wrap",      4'hA, 4'h3, 8'h5A, 1'b1, 1'b0, 12'h000, 1'b0);
    run_cycle(1'b0, 12'h000, 1'b0);

    // runEn dropped at cycle 3: instruction completes, then A1 holds.
    push("runen_drop",   4'hD, 4'h5, 8'h5A, 1'b1, 1'b0, 12'h001, 1'b0);
    run_cycle(1'b0, 12'h000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle:cycle", 32'(bus.cycle), 32'd0);
      chk("idle:sync",  32'(bus.sync),  32'd0);
    end
    chk("idle:romAddr", 32'(bus.romAddr), 32'h001);

    // Resume on JUN at 0x001, then reset at cycle 5 of its first cycle.
    bus.runEn = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst:cycle", 32'(bus.cycle), 32'd5);
    chk("pre_rst:opr",   32'(bus.opr),   32'h4);
    chk("pre_rst:exec",  32'(bus.exec),  32'd0);
    rstN = 1'b0;
    #1;
    chk_reset_state("mid_reset");
    step();
    rstN = 1'b1;

    push("restart",      4'hD, 4'h5, 8'h00, 1'b1, 1'b0, 12'h001, 1'b0);
    run_cycle(1'b0, 12'h000, 1'b0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h000, PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 SHALL have port rstN, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port runEn, input, 1, permits a new instruction cycle to start from A1.
REQ-005 SHALL have port romData, input, 8, ROM byte at romAddr; [7:4]=OPR, [3:0]=OPA.
REQ-006 SHALL have port pcLoad, input, 1, jump request, sampled at X3 only.
REQ-007 SHALL have port pcLoadAddr, input, 12, jump target, sampled with pcLoad.
REQ-008 SHALL have port romAddr, output, 12, registered PC driven to ROM.
REQ-009 SHALL have port cycle, output, 3, phase counter: 0..7 = A1,A2,A3,M1,M2,X1,X2,X3.
REQ-010 SHALL have port sync, output, 1, high while cycle==7 (X3).
REQ-011 SHALL have ports opr and opa, output, 4 each, first-word instruction nibbles to the decoder.
REQ-012 SHALL have port operand2, output, 8, second byte of a two-word instruction.
REQ-013 SHALL have port secondWord, output, 1, high during the second instruction cycle of a two-word instruction.
REQ-014 SHALL have port exec, output, 1, high for the instruction cycle in which the decoder executes.

Function
REQ-015 cycle SHALL advance by 1 per clk and wrap 7->0, except that at cycle==0 with runEn==0 it SHALL hold at 0.
REQ-016 An instruction cycle, once started (cycle left 0), SHALL always complete to X3 regardless of runEn.
REQ-017 Two-word decode SHALL be: OPR 1 (JCN), 2 with OPA[0]==0 (FIM), 4 (JUN), 5 (JMS), 7 (ISZ); all other codes are one-word.
REQ-018 The two-word decode SHALL be applied to romData at the cycle==4 (M2) edge.
REQ-019 FSM SHALL have two states: FIRST and SECOND; secondWord==1 iff state is SECOND.
REQ-020 At the M2 edge in FIRST, opr/opa SHALL be loaded from romData.
REQ-021 At the M2 edge in FIRST, exec SHALL load 1 for a one-word code and 0 for a two-word code.
REQ-022 At the M2 edge in SECOND, operand2 SHALL load romData; opr/opa SHALL hold; exec SHALL load 1.
REQ-023 exec, opr, opa and operand2 SHALL hold between M2 edges.
REQ-024 At the X3 edge, the PC SHALL load pcLoadAddr if pcLoad==1, else pc+1 modulo 4096 (0xFFF->0x000).
REQ-025 At the X3 edge, state SHALL go FIRST->SECOND when the latched code is two-word and pcLoad==0; otherwise state SHALL go to FIRST.
REQ-026 pcLoad SHALL take priority over the FIRST->SECOND transition.
REQ-027 pcLoad and pcLoadAddr SHALL be ignored at every cycle other than 7.
REQ-028 romAddr SHALL equal the PC register with no combinational path from inputs.

Reset
REQ-029 While rstN==0, the block SHALL asynchronously set cycle=0, PC=RESET_PC, state=FIRST.
REQ-030 While rstN==0, the block SHALL asynchronously set opr=0, opa=0, operand2=0, exec=0, secondWord=0, sync=0.
REQ-031 Reset asserted mid-instruction SHALL abandon that instruction; after release, fetch SHALL restart at A1 from RESET_PC.

Verification
REQ-032 Reset, runEn=1, ROM[0]=0xD5 -> at M2 edge opr=D, opa=5, exec=1; after X3 romAddr=0x001, secondWord=0.
REQ-033 ROM[1]=0x40, ROM[2]=0x23 -> first cycle: exec=0 -> next cycle: secondWord=1, operand2=0x23, exec=1, opr=4 -> pcLoad=1 with pcLoadAddr=0x423 at X3 -> romAddr=0x423, secondWord=0.
REQ-034 Consecutive fetches 0x22 then 0x21 -> 0x22 (FIM) gives secondWord=1 on the following cycle; 0x21 (SRC) gives exec=1 and stays FIRST.
REQ-035 PC forced to 0xFFF with a one-word opcode -> after X3 romAddr=0x000.
REQ-036 runEn dropped at cycle 3 -> cycle runs to 7, sync pulses one clk, then cycle holds 0; runEn=1 resumes at A1.
REQ-037 rstN pulsed low at cycle 5 of a two-word first cycle -> all outputs reset immediately; restart fetch at RESET_PC.
